// File: rtl/systolic_pkg.sv
// systolic_pkg: mode constants, FSM state type and the per-lane delay rule
// shared by the skew stream buffer and its lane sub-module.
package systolic_pkg;

    localparam int unsigned SKEW_MODE_FWD = 0;
    localparam int unsigned SKEW_MODE_REV = 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } skew_state_e;

    // Delay in cycles for lane i of an n-lane edge: i for skew, n-1-i for de-skew.
    function automatic int unsigned lane_delay(int unsigned i, int unsigned n, int unsigned mode);
        return (mode == SKEW_MODE_REV) ? (n - 1 - i) : i;
    endfunction

endpackage

// File: rtl/skew_lane.sv
// skew_lane: one lane of the skew buffer, a DEPTH-stage data+valid shift
// register that advances only when en is high. DEPTH=0 is a pure passthrough.
module skew_lane #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned DEPTH     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [DATAWIDTH-1:0] d_in,
    input  logic                 v_in,
    output logic [DATAWIDTH-1:0] d_out,
    output logic                 v_out
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst_n, en};
        assign d_out       = d_in;
        assign v_out       = v_in;
    end else begin : g_pipe
        localparam int unsigned PW = DEPTH * DATAWIDTH;

        // Stage k occupies bits [k*DATAWIDTH +: DATAWIDTH]; stage 0 is the input end.
        logic [PW-1:0]    data_q, data_d;
        logic [DEPTH-1:0] valid_q, valid_d;

        // Shift one stage toward the output when enabled, otherwise hold.
        always_comb begin
            data_d  = data_q;
            valid_d = valid_q;
            if (en) begin
                data_d  = PW'({data_q, d_in});
                valid_d = DEPTH'({valid_q, v_in});
            end
        end

        // Pipe registers, cleared asynchronously.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q  <= '0;
                valid_q <= '0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign d_out = data_q[(DEPTH-1)*DATAWIDTH +: DATAWIDTH];
        assign v_out = valid_q[DEPTH-1];
    end

endmodule

// File: rtl/skew_stream_buffer.sv
// skew_stream_buffer: turns a stream of N_SIZE-lane row vectors into a
// diagonal wavefront (MODE=0, lane i delayed i) or realigns one (MODE=1,
// lane i delayed N_SIZE-1-i). Tracks tiles, self-drains after last_in and
// freezes entirely on stall.
// Optional build macro SKEW_STREAM_STATS_EN adds vec_count / stall_cycles.
module skew_stream_buffer
    import systolic_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned N_SIZE    = 32,
    parameter int unsigned MODE      = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic                 last_in,
    input  logic [DATAWIDTH-1:0] in_A [N_SIZE],
    output logic                 in_ready,
    input  logic                 stall,
    output logic [DATAWIDTH-1:0] out [N_SIZE],
    output logic [N_SIZE-1:0]    out_valid,
    output logic                 busy,
    output logic                 tile_done
`ifdef SKEW_STREAM_STATS_EN
    ,
    output logic [31:0]          vec_count,
    output logic [31:0]          stall_cycles
`endif
);

    localparam int unsigned CW       = $clog2(N_SIZE);
    localparam int unsigned MODE_SEL = (MODE == SKEW_MODE_REV) ? SKEW_MODE_REV : SKEW_MODE_FWD;

    skew_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 acc;
    logic                 adv;
    logic [DATAWIDTH-1:0] lane_data [N_SIZE];
    logic [N_SIZE-1:0]    lane_valid;

    assign adv      = ~stall;
    assign in_ready = ~stall & (state_q != DRAIN);
    assign acc      = valid_in & in_ready;
    assign busy     = (state_q != IDLE);

    for (genvar g = 0; g < N_SIZE; g++) begin : g_lane
        skew_lane #(
            .DATAWIDTH (DATAWIDTH),
            .DEPTH     (lane_delay(g, N_SIZE, MODE_SEL))
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (adv),
            .d_in  (in_A[g]),
            .v_in  (acc),
            .d_out (lane_data[g]),
            .v_out (lane_valid[g])
        );
        assign out[g] = lane_valid[g] ? lane_data[g] : '0;
    end

    assign out_valid = lane_valid;

    // Tile FSM and drain countdown. tile_done is decoded from the current
    // count rather than registered so it lines up with the last tail element
    // leaving the deepest lane and drops to 0 in any stalled cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tile_done = 1'b0;
        case (state_q)
            IDLE, STREAM: begin
                if (acc) begin
                    if (last_in) begin
                        state_d = DRAIN;
                        cnt_d   = CW'(N_SIZE - 1);
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            DRAIN: begin
                if (!stall) begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d   = IDLE;
                        tile_done = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and drain counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SKEW_STREAM_STATS_EN
    logic [31:0] vec_count_q, vec_count_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Saturating counters: accepted vectors and stalled cycles while busy.
    always_comb begin
        vec_count_d    = vec_count_q;
        stall_cycles_d = stall_cycles_q;
        if (acc && (vec_count_q != '1)) begin
            vec_count_d = vec_count_q + 32'd1;
        end
        if (stall && busy && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_count_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            vec_count_q    <= vec_count_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign vec_count    = vec_count_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule
